// File: rtl/tone_dac_driver.sv
// tone_dac_driver
//   Turns the left/right tone frequencies from the music tables into two
//   phase-continuous square waves, scales them by a volume level, and
//   serialises the 16-bit stereo samples onto the four-wire audio DAC pins.
//
// Ports
//   clk         system clock, CLK_FREQ Hz
//   rst_n       asynchronous active-low reset
//   toneL/R     per-channel tone frequency in Hz (out-of-range = silent)
//   volume      amplitude level 0..7, 0 = silent
//   mute        forces both samples to zero
//   audio_mclk  DAC master clock, clk/4
//   audio_lrck  DAC word select, clk/512 (0 = left, 1 = right)
//   audio_sck   DAC bit clock, clk/8
//   audio_sdin  DAC serial data, MSB first, changes on sck falling edges

// One square-wave channel plus its signed sample.
//   clk, rst_n  clock / async reset
//   tone        frequency in Hz
//   volume      amplitude level
//   mute        forces the sample to zero
//   sample      signed 16-bit sample for this channel
module tone_dac_channel #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned MIN_TONE  = 20,
  parameter int unsigned MAX_TONE  = 20000,
  parameter int unsigned AMP_SHIFT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic [15:0] sample
);

  logic        valid;
  logic [31:0] acc;
  logic        sq;
  logic [32:0] acc_sum;
  logic        wrap;
  logic [15:0] amp;
  logic [15:0] amp_neg;

  assign valid = (tone >= MIN_TONE) && (tone <= MAX_TONE);

  // Adding 2*tone per clk and wrapping at CLK_FREQ gives two wraps (one
  // full square period) per 1/tone seconds. The extra bit keeps the sum
  // exact before the compare.
  assign acc_sum = {1'b0, acc} + {tone, 1'b0};
  assign wrap    = (acc_sum >= 33'(CLK_FREQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 32'd0;
      sq  <= 1'b0;
    end else if (!valid) begin
      acc <= 32'd0;
      sq  <= 1'b0;
    end else if (wrap) begin
      acc <= 32'(acc_sum - 33'(CLK_FREQ));
      sq  <= ~sq;
    end else begin
      acc <= acc_sum[31:0];
    end
  end

  assign amp     = 16'(volume) << AMP_SHIFT;
  assign amp_neg = 16'd0 - amp;

  always_comb begin
    sample = 16'd0;
    if (!mute && valid && (volume != 3'd0)) begin
      sample = sq ? amp : amp_neg;
    end
  end

endmodule

module tone_dac_driver #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned MIN_TONE  = 20,
  parameter int unsigned MAX_TONE  = 20000,
  parameter int unsigned AMP_SHIFT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] toneL,
  input  logic [31:0] toneR,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);

  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic [8:0]  ctr;
  logic [8:0]  ctr_nxt;
  logic        frame_boundary;
  logic [31:0] frame;
  logic [31:0] frame_src;
  logic [15:0] half_word;
  logic [3:0]  bit_idx;
  logic        sdin_nxt;

  tone_dac_channel #(
    .CLK_FREQ (CLK_FREQ),
    .MIN_TONE (MIN_TONE),
    .MAX_TONE (MAX_TONE),
    .AMP_SHIFT(AMP_SHIFT)
  ) u_chan_l (
    .clk   (clk),
    .rst_n (rst_n),
    .tone  (toneL),
    .volume(volume),
    .mute  (mute),
    .sample(sample_l)
  );

  tone_dac_channel #(
    .CLK_FREQ (CLK_FREQ),
    .MIN_TONE (MIN_TONE),
    .MAX_TONE (MAX_TONE),
    .AMP_SHIFT(AMP_SHIFT)
  ) u_chan_r (
    .clk   (clk),
    .rst_n (rst_n),
    .tone  (toneR),
    .volume(volume),
    .mute  (mute),
    .sample(sample_r)
  );

  assign ctr_nxt        = ctr + 9'd1;
  assign frame_boundary = (ctr == 9'd511);

  // On the boundary edge the new frame and its first bit load together,
  // so the serialiser looks at the incoming samples rather than the old
  // frame register.
  assign frame_src = frame_boundary ? {sample_l, sample_r} : frame;

  // Bit for the slot that begins after this edge: ctr[8] picks the half,
  // ctr[7] set means the padding part of the half.
  assign half_word = ctr_nxt[8] ? frame_src[15:0] : frame_src[31:16];
  assign bit_idx   = 4'd15 - ctr_nxt[6:3];
  assign sdin_nxt  = ctr_nxt[7] ? 1'b0 : half_word[bit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr        <= 9'd0;
      frame      <= 32'd0;
      audio_mclk <= 1'b0;
      audio_sck  <= 1'b0;
      audio_lrck <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      ctr        <= ctr_nxt;
      audio_mclk <= ctr_nxt[1];
      audio_sck  <= ctr_nxt[2];
      audio_lrck <= ctr_nxt[8];
      if (frame_boundary) begin
        frame <= {sample_l, sample_r};
      end
      // sdin only moves as sck falls, keeping it stable while sck is high.
      if (ctr[2:0] == 3'd7) begin
        audio_sdin <= sdin_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tone_dac_driver.sv
// Testbench for tone_dac_driver. The accumulator modulus is scaled down to
// 1 MHz so a 500 Hz square toggles every 1000 clk and several tone periods
// fit in a short run; expected frames are worked out by hand from
// sq = floor(edges * 2 * tone / CLK_FREQ) mod 2 at each frame boundary.
module tb_tone_dac_driver;

  localparam int unsigned CLK_FREQ_TB = 1000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tone_l = 32'd0;
  logic [31:0] tone_r = 32'd0;
  logic [2:0]  volume = 3'd0;
  logic        mute = 1'b0;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_edges;
  logic [8:0] tb_ctr;

  tone_dac_driver #(
    .CLK_FREQ (CLK_FREQ_TB),
    .MIN_TONE (20),
    .MAX_TONE (20000),
    .AMP_SHIFT(12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toneL     (tone_l),
    .toneR     (tone_r),
    .volume    (volume),
    .mute      (mute),
    .audio_mclk(audio_mclk),
    .audio_lrck(audio_lrck),
    .audio_sck (audio_sck),
    .audio_sdin(audio_sdin)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the frame position is its low 9 bits.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_edges <= 0;
    else        tb_edges <= tb_edges + 1;
  end
  assign tb_ctr = tb_edges[8:0];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [31:0] tl, input logic [31:0] tr,
                          input logic [2:0] vol, input logic mu);
    @(negedge clk);
    rst_n  = 1'b0;
    tone_l = tl;
    tone_r = tr;
    volume = vol;
    mute   = mu;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_edges(input int target);
    int guard = 0;
    while (tb_edges != target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (tb_edges != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_edges: reached %0d, required %0d", tb_edges, target);
    end
  endtask

  // Records sdin at every sck rising edge of frame k (ctr 0..511) and counts
  // any change of sdin during the rest of the sck-high phase.
  task automatic capture_frame(input int k, output logic [63:0] bits,
                               output int unstable);
    logic cur = 1'b0;
    wait_edges(512 * k);
    bits = 64'd0;
    unstable = 0;
    for (int i = 0; i < 512; i++) begin
      if (tb_ctr[2:0] == 3'd4) begin
        cur = audio_sdin;
        bits[63 - int'(tb_ctr[8:3])] = cur;
      end else if (tb_ctr[2:0] > 3'd4 && audio_sdin !== cur) begin
        unstable++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input int k,
                             input logic [15:0] l, input logic [15:0] r);
    logic [63:0] bits;
    logic [63:0] expv;
    int unstable;
    capture_frame(k, bits, unstable);
    expv = {l, 16'h0000, r, 16'h0000};
    n_cmp++;
    if (bits !== expv) begin
      n_bad++;
      $display("FAIL %s frame %0d: got %h required %h", name, k, bits, expv);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++;
      $display("FAIL %s frame %0d sdin_stable: got %0d changes required 0", name, k, unstable);
    end
  endtask

  task automatic test_reset;
    int rise_mclk = -1;
    int rise_sck = -1;
    int rise_lrck = -1;
    int rise_lrck2 = -1;
    logic prev_lrck = 1'b0;
    logic [2:0] expv;
    @(negedge clk);
    rst_n  = 1'b0;
    tone_l = 32'd500;
    tone_r = 32'd440;
    volume = 3'd7;
    mute   = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0000",
               {audio_mclk, audio_lrck, audio_sck, audio_sdin});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      expv = {tb_ctr[1], tb_ctr[2], tb_ctr[8]};
      n_cmp++;
      if ({audio_mclk, audio_sck, audio_lrck} !== expv) begin
        n_bad++;
        $display("FAIL clocks at edge %0d: got %b required %b", tb_edges,
                 {audio_mclk, audio_sck, audio_lrck}, expv);
      end
      if (audio_mclk === 1'b1 && rise_mclk < 0) rise_mclk = tb_edges;
      if (audio_sck === 1'b1 && rise_sck < 0) rise_sck = tb_edges;
      if (audio_lrck === 1'b1 && prev_lrck === 1'b0) begin
        if (rise_lrck < 0) rise_lrck = tb_edges;
        else if (rise_lrck2 < 0) rise_lrck2 = tb_edges;
      end
      prev_lrck = audio_lrck;
    end
    n_cmp++;
    if (rise_mclk != 2) begin
      n_bad++;
      $display("FAIL mclk_first_rise: got %0d required 2", rise_mclk);
    end
    n_cmp++;
    if (rise_sck != 4) begin
      n_bad++;
      $display("FAIL sck_first_rise: got %0d required 4", rise_sck);
    end
    n_cmp++;
    if (rise_lrck != 256) begin
      n_bad++;
      $display("FAIL lrck_first_rise: got %0d required 256", rise_lrck);
    end
    n_cmp++;
    if (rise_lrck2 != 768) begin
      n_bad++;
      $display("FAIL lrck_second_rise: got %0d required 768", rise_lrck2);
    end
  endtask

  // Left 500 Hz toggles every 1000 clk, right 20000 Hz every 25 clk.
  task automatic test_tone;
    do_reset(32'd500, 32'd20000, 3'd3, 1'b0);
    check_frame("tone", 1, 16'hD000, 16'hD000);
    check_frame("tone", 2, 16'h3000, 16'hD000);
    check_frame("tone", 3, 16'h3000, 16'h3000);
    check_frame("tone", 4, 16'hD000, 16'h3000);
  endtask

  // Called right after test_tone: the frame register holds live data.
  task automatic test_reset_mid_frame;
    wait_edges(2560 + 300);
    n_cmp++;
    if ({audio_lrck, audio_sck} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_clocks: got %b required 11", {audio_lrck, audio_sck});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({audio_mclk, audio_lrck, audio_sck, audio_sdin} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %b required 0000",
               {audio_mclk, audio_lrck, audio_sck, audio_sdin});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_frame("restart", 0, 16'h0000, 16'h0000);
    check_frame("restart", 1, 16'hD000, 16'hD000);
  endtask

  // 500 -> 1000 Hz after edge 1300: sq=1, acc=300000; next toggles at
  // edges 1650, 2150, 2650 with the 2000/clk increment.
  task automatic test_tone_change;
    do_reset(32'd500, 32'd50000000, 3'd3, 1'b0);
    fork
      begin
        wait_edges(1300);
        tone_l = 32'd1000;
      end
      begin
        check_frame("tone_change", 1, 16'hD000, 16'h0000);
        check_frame("tone_change", 2, 16'h3000, 16'h0000);
        check_frame("tone_change", 3, 16'h3000, 16'h0000);
        check_frame("tone_change", 4, 16'hD000, 16'h0000);
        check_frame("tone_change", 5, 16'h3000, 16'h0000);
        check_frame("tone_change", 6, 16'hD000, 16'h0000);
      end
    join
  endtask

  // 440 Hz: sq=0 at the first boundary, sq=1 at the third.
  task automatic test_mute;
    do_reset(32'd440, 32'd440, 3'd7, 1'b0);
    fork
      begin
        wait_edges(700);
        mute = 1'b1;
        wait_edges(1100);
        mute = 1'b0;
      end
      begin
        check_frame("mute", 1, 16'h9000, 16'h9000);
        check_frame("mute", 2, 16'h0000, 16'h0000);
        check_frame("mute", 3, 16'h7000, 16'h7000);
      end
    join
  endtask

  task automatic test_boundaries;
    do_reset(32'd20, 32'd19, 3'd1, 1'b0);
    check_frame("min_tone", 1, 16'hF000, 16'h0000);
    do_reset(32'd20001, 32'd20000, 3'd1, 1'b0);
    check_frame("max_tone", 1, 16'h0000, 16'hF000);
    do_reset(32'd500, 32'd500, 3'd0, 1'b0);
    check_frame("volume_zero", 1, 16'h0000, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_tone();
    test_reset_mid_frame();
    test_tone_change();
    test_mute();
    test_boundaries();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
